// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, FSM state type and opcode legality check for the
// ALU command sequencer and its optional reference model.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_NOT   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NAND  = 4'b0100;
    localparam logic [3:0] OP_NOR   = 4'b0101;
    localparam logic [3:0] OP_XNOR  = 4'b0110;
    localparam logic [3:0] OP_ADD   = 4'b1000;
    localparam logic [3:0] OP_SUB   = 4'b1001;
    localparam logic [3:0] OP_SHR   = 4'b1010;
    localparam logic [3:0] OP_SHL   = 4'b1011;
    localparam logic [3:0] OP_CLEAR = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_CLEAR
    } state_t;

    function automatic logic is_legal_opcode(input logic [3:0] opcode);
        case (opcode)
            4'b0111, 4'b1100, 4'b1101, 4'b1110: return 1'b0;
            default:                            return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational expected-result model of the 16-bit ALU; only compiled when
// ALU_SEQ_SELFCHECK_EN is defined.
`ifdef ALU_SEQ_SELFCHECK_EN
module alu_ref_model
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] expected
);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        expected = '0;
        case (opcode)
            OP_AND:  expected = a & b;
            OP_OR:   expected = a | b;
            OP_NOT:  expected = ~a;
            OP_XOR:  expected = a ^ b;
            OP_NAND: expected = ~(a & b);
            OP_NOR:  expected = ~(a | b);
            OP_XNOR: expected = ~(a ^ b);
            OP_ADD:  expected = a + b;
            OP_SUB:  expected = a - b;
            OP_SHR:  expected = a >> 1;
            OP_SHL:  expected = a << 1;
            default: expected = '0;
        endcase
    end

endmodule
`endif

// File: rtl/alu_cmd_sequencer.sv
// Valid/ready command initiator for the ALU: issue, wait latency, return result,
// then clear. Optional result self-check under ALU_SEQ_SELFCHECK_EN.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ALU_LATENCY = 1,
    parameter int WIDTH       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_opcode,
    output logic             rsp_err,
    output logic             busy,
    output logic [15:0]      op_count
`ifdef ALU_SEQ_SELFCHECK_EN
    ,
    output logic             mismatch
`endif
);

    localparam int CNT_W = 4;

    state_t             state;
    state_t             state_next;
    logic [3:0]         lat_opcode;
    logic [WIDTH-1:0]   lat_a;
    logic [WIDTH-1:0]   lat_b;
    logic [CNT_W-1:0]   wait_cnt;
    logic               cmd_fire;
    logic               cmd_legal;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign cmd_legal = is_legal_opcode(cmd_opcode);

`ifdef ALU_SEQ_SELFCHECK_EN
    logic [WIDTH-1:0] expected;

    alu_ref_model #(.WIDTH(WIDTH)) u_ref_model (
        .opcode   (lat_opcode),
        .a        (lat_a),
        .b        (lat_b),
        .expected (expected)
    );
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (cmd_fire) state_next = cmd_legal ? ST_ISSUE : ST_RESP;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (wait_cnt == '0) state_next = ST_RESP;
            ST_RESP:  if (rsp_ready) state_next = ST_CLEAR;
            ST_CLEAR: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Counter covers the ALU latency plus the edge the operands need to reach it,
    // so the capture lands on the first edge where the result is settled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            lat_opcode <= '0;
            lat_a      <= '0;
            lat_b      <= '0;
            wait_cnt   <= '0;
            alu_opcode <= OP_CLEAR;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_opcode <= '0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
`ifdef ALU_SEQ_SELFCHECK_EN
            mismatch   <= 1'b0;
`endif
        end else begin
            cmd_ready <= (state_next == ST_IDLE);
            busy      <= (state_next != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        lat_opcode <= cmd_opcode;
                        lat_a      <= cmd_a;
                        lat_b      <= cmd_b;
                        if (!cmd_legal) begin
                            rsp_valid  <= 1'b1;
                            rsp_err    <= 1'b1;
                            rsp_data   <= '0;
                            rsp_opcode <= cmd_opcode;
`ifdef ALU_SEQ_SELFCHECK_EN
                            mismatch   <= 1'b0;
`endif
                        end
                    end
                end
                ST_ISSUE: begin
                    alu_opcode <= lat_opcode;
                    alu_a      <= lat_a;
                    alu_b      <= lat_b;
                    wait_cnt   <= CNT_W'(ALU_LATENCY);
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        rsp_valid  <= 1'b1;
                        rsp_err    <= 1'b0;
                        rsp_data   <= alu_result;
                        rsp_opcode <= lat_opcode;
`ifdef ALU_SEQ_SELFCHECK_EN
                        mismatch   <= (alu_result != expected);
`endif
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        alu_opcode <= OP_CLEAR;
                        alu_a      <= '0;
                        alu_b      <= '0;
                        if (!rsp_err && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
`ifdef ALU_SEQ_SELFCHECK_EN
                        mismatch   <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a pipelined ALU stand-in; latency 1
// and latency 3 instances. Self-check vectors run when ALU_SEQ_SELFCHECK_EN is set.
module tb_alu_cmd_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid, cmd_valid_3, rsp_ready, force_en;
    logic [3:0]   cmd_opcode;
    logic [W-1:0] cmd_a, cmd_b;

    logic         cmd_ready, rsp_valid, rsp_err, busy;
    logic [3:0]   alu_opcode, rsp_opcode;
    logic [W-1:0] alu_a, alu_b, alu_result, rsp_data;
    logic [15:0]  op_count;

    logic         cmd_ready_3, rsp_valid_3, rsp_err_3, busy_3;
    logic [3:0]   alu_opcode_3, rsp_opcode_3;
    logic [W-1:0] alu_a_3, alu_b_3, alu_result_3, rsp_data_3;
    logic [15:0]  op_count_3;
`ifdef ALU_SEQ_SELFCHECK_EN
    logic         mismatch, mismatch_3;
`endif

    int n_pass = 0;
    int n_checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.ALU_LATENCY(1), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_opcode(rsp_opcode), .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
`ifdef ALU_SEQ_SELFCHECK_EN
        , .mismatch(mismatch)
`endif
    );

    alu_cmd_sequencer #(.ALU_LATENCY(3), .WIDTH(W)) dut_3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_3), .cmd_ready(cmd_ready_3),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_opcode(alu_opcode_3), .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_result(alu_result_3),
        .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready), .rsp_data(rsp_data_3),
        .rsp_opcode(rsp_opcode_3), .rsp_err(rsp_err_3), .busy(busy_3), .op_count(op_count_3)
`ifdef ALU_SEQ_SELFCHECK_EN
        , .mismatch(mismatch_3)
`endif
    );

    // Stand-in for the ALU breadboard: registered, one stage per latency cycle.
    function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return ~a;
            4'b0011: return a ^ b;
            4'b0100: return ~(a & b);
            4'b0101: return ~(a | b);
            4'b0110: return ~(a ^ b);
            4'b1000: return a + b;
            4'b1001: return a - b;
            4'b1010: return a >> 1;
            4'b1011: return a << 1;
            default: return '0;
        endcase
    endfunction

    logic [W-1:0] pipe_1;
    logic [W-1:0] pipe_3 [3];

    always @(posedge clk) begin
        pipe_1    <= alu_f(alu_opcode, alu_a, alu_b);
        pipe_3[0] <= alu_f(alu_opcode_3, alu_a_3, alu_b_3);
        pipe_3[1] <= pipe_3[0];
        pipe_3[2] <= pipe_3[1];
    end

    assign alu_result   = force_en ? 16'h1234 : pipe_1;
    assign alu_result_3 = pipe_3[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Presents a command and returns the cycle index of the accepting edge.
    task automatic send(input bit which, input logic [3:0] op, input logic [W-1:0] a, b,
                        output int k);
        int n;
        n = 0;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        if (which) cmd_valid_3 = 1'b1;
        else       cmd_valid   = 1'b1;
        while (!(which ? cmd_ready_3 : cmd_ready) && n < 50) begin
            step();
            n++;
        end
        check("cmd_ready_bound", 32'(n < 50), 32'd1);
        step();
        k           = cyc;
        cmd_valid   = 1'b0;
        cmd_valid_3 = 1'b0;
    endtask

    task automatic wait_rsp(input bit which, input int k, output int lat);
        int n;
        n = 0;
        while (!(which ? rsp_valid_3 : rsp_valid) && n < 60) begin
            step();
            n++;
        end
        lat = cyc - k;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, k2, lat;
        logic seen;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_valid_3 = 1'b0; rsp_ready = 1'b1; force_en = 1'b0;
        cmd_opcode = '0; cmd_a = '0; cmd_b = '0;
        #12;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_alu_opcode", alu_opcode, 4'hF);
        check("rst_alu_a", alu_a, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_busy", busy, 0);
        check("rst_op_count", op_count, 0);
        #10 rst_n = 1'b1;
        step();

        // AND 0x000A & 0x0003, latency 1
        send(0, 4'b0000, 16'h000A, 16'h0003, k);
        check("and_cmd_ready_low", cmd_ready, 0);
        check("and_busy", busy, 1);
        step();
        check("and_alu_opcode", alu_opcode, 4'b0000);
        check("and_alu_a", alu_a, 16'h000A);
        check("and_alu_b", alu_b, 16'h0003);
        wait_rsp(0, k, lat);
        check("and_latency", lat, 3);
        check("and_rsp_data", rsp_data, 16'h0002);
        check("and_rsp_opcode", rsp_opcode, 4'b0000);
        check("and_rsp_err", rsp_err, 0);
        step();
        check("and_rsp_valid_drop", rsp_valid, 0);
        check("and_clear_opcode", alu_opcode, 4'hF);
        check("and_clear_a", alu_a, 0);
        check("and_op_count", op_count, 1);
        check("and_clear_not_ready", cmd_ready, 0);
        step();
        check("and_idle_ready", cmd_ready, 1);

        // ADD then SUB back-to-back
        send(0, 4'b1000, 16'h0002, 16'h0003, k);
        wait_rsp(0, k, lat);
        check("add_latency", lat, 3);
        check("add_rsp_data", rsp_data, 16'h0005);
        send(0, 4'b1001, 16'h0006, 16'h0003, k2);
        check("add_sub_spacing", 32'((k2 - k) >= 5), 32'd1);
        wait_rsp(0, k2, lat);
        check("sub_rsp_data", rsp_data, 16'h0003);
        check("sub_rsp_opcode", rsp_opcode, 4'b1001);
        step();
        check("sub_op_count", op_count, 3);

        // SHL with backpressure
        rsp_ready = 1'b0;
        send(0, 4'b1011, 16'h0002, 16'h0000, k);
        wait_rsp(0, k, lat);
        check("shl_rsp_data", rsp_data, 16'h0004);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_rsp_valid_held", rsp_valid, 1);
            check("bp_rsp_data_stable", rsp_data, 16'h0004);
        end
        check("bp_op_count_held", op_count, 3);
        rsp_ready = 1'b1;
        step();
        check("bp_handshake", rsp_valid, 0);
        check("bp_op_count", op_count, 4);

        // Illegal opcode 0111
        send(0, 4'b0111, 16'h0055, 16'h00AA, k);
        check("ill_rsp_valid", rsp_valid, 1);
        check("ill_rsp_err", rsp_err, 1);
        check("ill_rsp_data", rsp_data, 0);
        check("ill_rsp_opcode", rsp_opcode, 4'b0111);
        check("ill_alu_opcode", alu_opcode, 4'hF);
        step();
        check("ill_rsp_valid_drop", rsp_valid, 0);
        check("ill_alu_opcode_after", alu_opcode, 4'hF);
        check("ill_op_count", op_count, 4);
        step();

        // Reset during WAIT on the latency-3 instance
        send(1, 4'b1000, 16'h0010, 16'h0020, k);
        step();
        step();
        check("rmid_busy_before", busy_3, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rmid_busy", busy_3, 0);
        check("rmid_cmd_ready", cmd_ready_3, 1);
        check("rmid_alu_opcode", alu_opcode_3, 4'hF);
        check("rmid_alu_a", alu_a_3, 0);
        check("rmid_rsp_valid", rsp_valid_3, 0);
        check("rmid_op_count_lat1", op_count, 0);
        #3 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rsp_valid_3) seen = 1'b1;
        end
        check("rmid_no_response", seen, 0);
        send(1, 4'b1001, 16'h0009, 16'h0004, k);
        wait_rsp(1, k, lat);
        check("rmid_next_latency", lat, 5);
        check("rmid_next_data", rsp_data_3, 16'h0005);
        step();
        check("rmid_next_op_count", op_count_3, 1);
        step();

`ifdef ALU_SEQ_SELFCHECK_EN
        send(0, 4'b0110, 16'h0006, 16'h0003, k);
        wait_rsp(0, k, lat);
        check("sc_xnor_data", rsp_data, 16'hFFFA);
        check("sc_xnor_mismatch", mismatch, 0);
        step();
        force_en = 1'b1;
        send(0, 4'b0000, 16'h0001, 16'h0001, k);
        wait_rsp(0, k, lat);
        check("sc_forced_valid", rsp_valid, 1);
        check("sc_forced_data", rsp_data, 16'h1234);
        check("sc_forced_mismatch", mismatch, 1);
        step();
        check("sc_mismatch_cleared", mismatch, 0);
        force_en = 1'b0;
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
